idma_job_sched: RTL and testbench

- Descriptor scheduler in front of the tile iDMA's two transfer channels: AXI2OBI (L2 to L1) and OBI2AXI (L1 to L2).
- Accepts 1D transfer jobs from NUM_REQ requesters (core, event unit, ...) and arbitrates them round-robin into per-direction FIFOs.
- Sequences each channel through issue, start and done/error, then returns one completion per job tagged with its requester ID.
- Both directions run concurrently; jobs within one direction are strictly serialised.

---
 rtl/idma_job_sched_pkg.sv | 20 ++
 rtl/idma_job_sched_chan_fsm.sv | 120 ++++++++++++
 rtl/idma_job_sched.sv | 217 +++++++++++++++++++++
 tb/tb_idma_job_sched.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idma_job_sched_pkg.sv
// Shared types and helpers for the iDMA job scheduler: channel FSM states,
// direction encodings and the round-robin pointer step.
package idma_job_sched_pkg;

   localparam logic DIR_A2O = 1'b0;
   localparam logic DIR_O2A = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_START,
      WAIT_DONE,
      COMPLETE
   } sched_state_e;

   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/idma_job_sched_chan_fsm.sv
// Per-channel sequencer: holds the active job, walks it through issue/start/done
// and raises a completion request until the shared completion port grants it.
module idma_job_chan_fsm
   import idma_job_sched_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 32,
   parameter int ID_W   = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              fifo_empty_i,
   input  logic [ID_W-1:0]   head_id_i,
   input  logic [ADDR_W-1:0] head_src_i,
   input  logic [ADDR_W-1:0] head_dst_i,
   input  logic [LEN_W-1:0]  head_len_i,
   output logic              pop_o,
   output logic              cfg_valid_o,
   input  logic              cfg_ready_i,
   output logic [ADDR_W-1:0] cfg_src_o,
   output logic [ADDR_W-1:0] cfg_dst_o,
   output logic [LEN_W-1:0]  cfg_len_o,
   input  logic              start_i,
   input  logic              done_i,
   input  logic              error_i,
   output logic              cpl_req_o,
   input  logic              cpl_gnt_i,
   output logic              cpl_err_o,
   output logic [ID_W-1:0]   cpl_id_o,
   output sched_state_e      state_o
);

   sched_state_e      state_q;
   logic              cfg_valid_q;
   logic              err_q;
   logic [ID_W-1:0]   id_q;
   logic [ADDR_W-1:0] src_q;
   logic [ADDR_W-1:0] dst_q;
   logic [LEN_W-1:0]  len_q;

   // A granted completion frees the job register, so the next job loads in the same cycle.
   assign pop_o = !fifo_empty_i &&
                  ((state_q == IDLE) || ((state_q == COMPLETE) && cpl_gnt_i));

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         state_q     <= IDLE;
         cfg_valid_q <= 1'b0;
         err_q       <= 1'b0;
         id_q        <= '0;
         src_q       <= '0;
         dst_q       <= '0;
         len_q       <= '0;
      end else begin
         unique case (state_q)
            IDLE, COMPLETE: begin
               if (pop_o) begin
                  id_q  <= head_id_i;
                  src_q <= head_src_i;
                  dst_q <= head_dst_i;
                  len_q <= head_len_i;
                  err_q <= 1'b0;
                  // Zero-length jobs never touch the channel.
                  if (head_len_i == '0) begin
                     state_q     <= COMPLETE;
                     cfg_valid_q <= 1'b0;
                  end else begin
                     state_q     <= ISSUE;
                     cfg_valid_q <= 1'b1;
                  end
               end else if ((state_q == COMPLETE) && cpl_gnt_i) begin
                  state_q <= IDLE;
                  err_q   <= 1'b0;
               end
            end
            ISSUE: begin
               if (cfg_ready_i) begin
                  state_q     <= WAIT_START;
                  cfg_valid_q <= 1'b0;
               end
            end
            WAIT_START: begin
               if (error_i) begin
                  state_q <= COMPLETE;
                  err_q   <= 1'b1;
               end else if (start_i && done_i) begin
                  state_q <= COMPLETE;
                  err_q   <= 1'b0;
               end else if (start_i) begin
                  state_q <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (error_i) begin
                  state_q <= COMPLETE;
                  err_q   <= 1'b1;
               end else if (done_i) begin
                  state_q <= COMPLETE;
                  err_q   <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               cfg_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign cfg_valid_o = cfg_valid_q;
   assign cfg_src_o   = src_q;
   assign cfg_dst_o   = dst_q;
   assign cfg_len_o   = len_q;
   assign cpl_req_o   = (state_q == COMPLETE);
   assign cpl_err_o   = err_q;
   assign cpl_id_o    = id_q;
   assign state_o     = state_q;

endmodule

// File: rtl/idma_job_sched.sv
// iDMA job scheduler: round-robin intake from NUM_REQ requesters into per-direction
// job FIFOs, two concurrent channel sequencers and a shared completion port.
module idma_job_sched
   import idma_job_sched_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int QUEUE_DEPTH = 4,
   parameter int ADDR_W      = 32,
   parameter int LEN_W       = 32,
   parameter int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        clear_i,
   input  logic [NUM_REQ-1:0]          req_valid_i,
   output logic [NUM_REQ-1:0]          req_ready_o,
   input  logic [NUM_REQ-1:0]          req_dir_i,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_src_i,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_dst_i,
   input  logic [NUM_REQ*LEN_W-1:0]    req_len_i,
   output logic                        a2o_cfg_valid_o,
   input  logic                        a2o_cfg_ready_i,
   output logic [ADDR_W-1:0]           a2o_cfg_src_o,
   output logic [ADDR_W-1:0]           a2o_cfg_dst_o,
   output logic [LEN_W-1:0]            a2o_cfg_len_o,
   input  logic                        a2o_start_i,
   input  logic                        a2o_done_i,
   input  logic                        a2o_error_i,
   output logic                        o2a_cfg_valid_o,
   input  logic                        o2a_cfg_ready_i,
   output logic [ADDR_W-1:0]           o2a_cfg_src_o,
   output logic [ADDR_W-1:0]           o2a_cfg_dst_o,
   output logic [LEN_W-1:0]            o2a_cfg_len_o,
   input  logic                        o2a_start_i,
   input  logic                        o2a_done_i,
   input  logic                        o2a_error_i,
   output logic                        cpl_valid_o,
   output logic [ID_W-1:0]             cpl_id_o,
   output logic                        cpl_dir_o,
   output logic                        cpl_error_o,
   output logic [$clog2(QUEUE_DEPTH)+1:0] a2o_pending_o,
   output logic [$clog2(QUEUE_DEPTH)+1:0] o2a_pending_o,
   output logic                        busy_o
);

   localparam int PTR_W  = $clog2(QUEUE_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int PEND_W = PTR_W + 2;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] src;
      logic [ADDR_W-1:0] dst;
      logic [LEN_W-1:0]  len;
   } job_t;

   logic [ID_W-1:0]        rr_q;
   logic                   gnt_found;
   logic [ID_W-1:0]        gnt_idx;
   job_t                   push_job;
   logic [1:0]             fifo_full;
   logic [1:0]             fifo_empty;
   logic [1:0]             fifo_push;
   logic [1:0]             fifo_pop;
   logic [1:0][CNT_W-1:0]  fifo_cnt;
   job_t [1:0]             head_job;
   logic [1:0]             cpl_req;
   logic [1:0]             cpl_gnt;
   logic [1:0]             cpl_err;
   logic [1:0][ID_W-1:0]   cpl_id;
   sched_state_e           chan_state [2];

   // Requester intake: first eligible requester at or after the RR pointer.
   always_comb begin
      int idx;
      gnt_found   = 1'b0;
      gnt_idx     = '0;
      req_ready_o = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_q) + k) % NUM_REQ;
         if (!gnt_found && req_valid_i[idx] && !fifo_full[req_dir_i[idx]]) begin
            gnt_found = 1'b1;
            gnt_idx   = ID_W'(idx);
         end
      end
      if (clear_i) gnt_found = 1'b0;
      if (gnt_found) req_ready_o[gnt_idx] = 1'b1;
   end

   assign push_job.id  = gnt_idx;
   assign push_job.src = req_src_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
   assign push_job.dst = req_dst_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
   assign push_job.len = req_len_i[int'(gnt_idx)*LEN_W +: LEN_W];

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         rr_q <= '0;
      end else if (gnt_found) begin
         rr_q <= ID_W'(rr_next(int'(gnt_idx), NUM_REQ));
      end
   end

   for (genvar d = 0; d < 2; d++) begin : g_fifo
      job_t             mem_q [QUEUE_DEPTH];
      logic [PTR_W-1:0] wptr_q;
      logic [PTR_W-1:0] rptr_q;
      logic [CNT_W-1:0] cnt_q;

      assign fifo_push[d]  = gnt_found && (req_dir_i[gnt_idx] == (d == 1));
      assign fifo_full[d]  = (cnt_q == CNT_W'(QUEUE_DEPTH));
      assign fifo_empty[d] = (cnt_q == '0);
      assign fifo_cnt[d]   = cnt_q;
      assign head_job[d]   = mem_q[rptr_q];

      // Pointers wrap naturally because the depth is a power of two.
      always_ff @(posedge clk_i) begin
         if (!rst_ni || clear_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
         end else begin
            if (fifo_push[d]) wptr_q <= wptr_q + 1'b1;
            if (fifo_pop[d])  rptr_q <= rptr_q + 1'b1;
            unique case ({fifo_push[d], fifo_pop[d]})
               2'b10:   cnt_q <= cnt_q + 1'b1;
               2'b01:   cnt_q <= cnt_q - 1'b1;
               default: cnt_q <= cnt_q;
            endcase
         end
      end

      always_ff @(posedge clk_i) begin
         if (fifo_push[d]) mem_q[wptr_q] <= push_job;
      end
   end

   idma_job_chan_fsm #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W),
      .ID_W   (ID_W)
   ) i_a2o_fsm (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (clear_i),
      .fifo_empty_i (fifo_empty[DIR_A2O]),
      .head_id_i    (head_job[DIR_A2O].id),
      .head_src_i   (head_job[DIR_A2O].src),
      .head_dst_i   (head_job[DIR_A2O].dst),
      .head_len_i   (head_job[DIR_A2O].len),
      .pop_o        (fifo_pop[DIR_A2O]),
      .cfg_valid_o  (a2o_cfg_valid_o),
      .cfg_ready_i  (a2o_cfg_ready_i),
      .cfg_src_o    (a2o_cfg_src_o),
      .cfg_dst_o    (a2o_cfg_dst_o),
      .cfg_len_o    (a2o_cfg_len_o),
      .start_i      (a2o_start_i),
      .done_i       (a2o_done_i),
      .error_i      (a2o_error_i),
      .cpl_req_o    (cpl_req[DIR_A2O]),
      .cpl_gnt_i    (cpl_gnt[DIR_A2O]),
      .cpl_err_o    (cpl_err[DIR_A2O]),
      .cpl_id_o     (cpl_id[DIR_A2O]),
      .state_o      (chan_state[0])
   );

   idma_job_chan_fsm #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W),
      .ID_W   (ID_W)
   ) i_o2a_fsm (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (clear_i),
      .fifo_empty_i (fifo_empty[DIR_O2A]),
      .head_id_i    (head_job[DIR_O2A].id),
      .head_src_i   (head_job[DIR_O2A].src),
      .head_dst_i   (head_job[DIR_O2A].dst),
      .head_len_i   (head_job[DIR_O2A].len),
      .pop_o        (fifo_pop[DIR_O2A]),
      .cfg_valid_o  (o2a_cfg_valid_o),
      .cfg_ready_i  (o2a_cfg_ready_i),
      .cfg_src_o    (o2a_cfg_src_o),
      .cfg_dst_o    (o2a_cfg_dst_o),
      .cfg_len_o    (o2a_cfg_len_o),
      .start_i      (o2a_start_i),
      .done_i       (o2a_done_i),
      .error_i      (o2a_error_i),
      .cpl_req_o    (cpl_req[DIR_O2A]),
      .cpl_gnt_i    (cpl_gnt[DIR_O2A]),
      .cpl_err_o    (cpl_err[DIR_O2A]),
      .cpl_id_o     (cpl_id[DIR_O2A]),
      .state_o      (chan_state[1])
   );

   // a2o always wins the completion port; o2a simply holds its request.
   assign cpl_gnt[DIR_A2O] = cpl_req[DIR_A2O];
   assign cpl_gnt[DIR_O2A] = cpl_req[DIR_O2A] && !cpl_req[DIR_A2O];

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         cpl_valid_o <= 1'b0;
         cpl_id_o    <= '0;
         cpl_dir_o   <= 1'b0;
         cpl_error_o <= 1'b0;
      end else begin
         cpl_valid_o <= |cpl_gnt;
         cpl_id_o    <= cpl_gnt[DIR_A2O] ? cpl_id[DIR_A2O]  : cpl_id[DIR_O2A];
         cpl_dir_o   <= cpl_gnt[DIR_A2O] ? DIR_A2O          : DIR_O2A;
         cpl_error_o <= cpl_gnt[DIR_A2O] ? cpl_err[DIR_A2O] : cpl_err[DIR_O2A];
      end
   end

   assign a2o_pending_o = PEND_W'(fifo_cnt[DIR_A2O]) + PEND_W'(chan_state[0] != IDLE);
   assign o2a_pending_o = PEND_W'(fifo_cnt[DIR_O2A]) + PEND_W'(chan_state[1] != IDLE);
   assign busy_o        = (a2o_pending_o != '0) || (o2a_pending_o != '0);

endmodule

// File: tb/tb_idma_job_sched.sv
// Directed bench for idma_job_sched: single job, contention, full FIFO, error paths,
// simultaneous completion, flush and zero-length jobs, with a completion scoreboard.
module tb_idma_job_sched;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              clear_i;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [1:0]        req_dir;
   logic [1:0][31:0]  rsrc;
   logic [1:0][31:0]  rdst;
   logic [1:0][31:0]  rlen;
   logic [1:0]        cfg_vld;
   logic [1:0]        cfg_rdy;
   logic [1:0][31:0]  cfg_src;
   logic [1:0][31:0]  cfg_dst;
   logic [1:0][31:0]  cfg_len;
   logic [1:0]        start;
   logic [1:0]        done;
   logic [1:0]        err;
   logic              cpl_valid;
   logic [0:0]        cpl_id;
   logic              cpl_dir;
   logic              cpl_err;
   logic [1:0][3:0]   pend;
   logic              busy;

   int                n_vec = 0;
   int                n_err = 0;
   int                cpl_cnt = 0;
   logic [2:0]        exp_q[$];

   always #5 clk_i = ~clk_i;

   idma_job_sched dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .clear_i         (clear_i),
      .req_valid_i     (req_valid),
      .req_ready_o     (req_ready),
      .req_dir_i       (req_dir),
      .req_src_i       (rsrc),
      .req_dst_i       (rdst),
      .req_len_i       (rlen),
      .a2o_cfg_valid_o (cfg_vld[0]),
      .a2o_cfg_ready_i (cfg_rdy[0]),
      .a2o_cfg_src_o   (cfg_src[0]),
      .a2o_cfg_dst_o   (cfg_dst[0]),
      .a2o_cfg_len_o   (cfg_len[0]),
      .a2o_start_i     (start[0]),
      .a2o_done_i      (done[0]),
      .a2o_error_i     (err[0]),
      .o2a_cfg_valid_o (cfg_vld[1]),
      .o2a_cfg_ready_i (cfg_rdy[1]),
      .o2a_cfg_src_o   (cfg_src[1]),
      .o2a_cfg_dst_o   (cfg_dst[1]),
      .o2a_cfg_len_o   (cfg_len[1]),
      .o2a_start_i     (start[1]),
      .o2a_done_i      (done[1]),
      .o2a_error_i     (err[1]),
      .cpl_valid_o     (cpl_valid),
      .cpl_id_o        (cpl_id),
      .cpl_dir_o       (cpl_dir),
      .cpl_error_o     (cpl_err),
      .a2o_pending_o   (pend[0]),
      .o2a_pending_o   (pend[1]),
      .busy_o          (busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   // Scoreboard: every completion pulse must match the oldest expected {id, dir, err}.
   always @(negedge clk_i) begin
      if (rst_ni && cpl_valid) begin
         cpl_cnt++;
         if (exp_q.size() == 0) chk("cpl_unexpected", 64'({cpl_id, cpl_dir, cpl_err}), 64'h7f);
         else chk("cpl", 64'({cpl_id, cpl_dir, cpl_err}), 64'(exp_q.pop_front()));
      end
   end

   task automatic send(input int r, input logic dir, input logic [31:0] src,
                       input logic [31:0] dst, input logic [31:0] len);
      int n = 0;
      req_valid[r] = 1'b1;
      req_dir[r]   = dir;
      rsrc[r]      = src;
      rdst[r]      = dst;
      rlen[r]      = len;
      #1;
      while (!req_ready[r] && n < 20) begin
         cyc();
         #1;
         n++;
      end
      chk("accept", 64'(req_ready[r]), 64'd1);
      cyc();
      req_valid[r] = 1'b0;
   endtask

   // Walks a channel from cfg_valid to COMPLETE. mode 0: start then done,
   // 1: start then error, 2: start then error+done, 3: start+done together.
   task automatic serve(input int d, input logic [31:0] src, input logic [31:0] len, input int mode);
      int n = 0;
      while (!cfg_vld[d] && n < 20) begin
         cyc();
         n++;
      end
      chk("cfg_valid", 64'(cfg_vld[d]), 64'd1);
      chk("cfg_src", 64'(cfg_src[d]), 64'(src));
      chk("cfg_len", 64'(cfg_len[d]), 64'(len));
      cfg_rdy[d] = 1'b1;
      cyc();
      cfg_rdy[d] = 1'b0;
      chk("cfg_drop", 64'(cfg_vld[d]), 64'd0);
      if (mode == 3) begin
         start[d] = 1'b1;
         done[d]  = 1'b1;
         cyc();
         start[d] = 1'b0;
         done[d]  = 1'b0;
      end else begin
         start[d] = 1'b1;
         cyc();
         start[d] = 1'b0;
         cyc();
         done[d] = (mode == 0) || (mode == 2);
         err[d]  = (mode == 1) || (mode == 2);
         cyc();
         done[d] = 1'b0;
         err[d]  = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int snap;
      rst_ni = 1'b0; clear_i = 1'b0;
      req_valid = '0; req_dir = '0; rsrc = '0; rdst = '0; rlen = '0;
      cfg_rdy = '0; start = '0; done = '0; err = '0;
      repeat (3) cyc();
      chk("rst_cfg_valid", 64'(cfg_vld), 64'd0);
      chk("rst_cpl_valid", 64'(cpl_valid), 64'd0);
      chk("rst_pending", 64'(pend), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rst_ni = 1'b1;
      cyc();

      // Single job on a2o.
      exp_q.push_back(3'b000);
      send(0, 1'b0, 32'h1000_0000, 32'h0000_0100, 32'd64);
      chk("t1_cfg_c1", 64'(cfg_vld[0]), 64'd0);
      chk("t1_pend_c1", 64'(pend[0]), 64'd1);
      chk("t1_busy", 64'(busy), 64'd1);
      cyc();
      chk("t1_cfg_c2", 64'(cfg_vld[0]), 64'd1);
      chk("t1_dst", 64'(cfg_dst[0]), 64'h100);
      serve(0, 32'h1000_0000, 32'd64, 0);
      chk("t1_pend_cpl", 64'(pend[0]), 64'd1);
      cyc();
      chk("t1_cpl", 64'(cpl_valid), 64'd1);
      chk("t1_pend_end", 64'(pend[0]), 64'd0);
      chk("t1_busy_end", 64'(busy), 64'd0);
      cyc();
      chk("t1_cpl_pulse", 64'(cpl_valid), 64'd0);

      // Contention on o2a; clear first to put the RR pointer back at 0.
      clear_i = 1'b1;
      cyc();
      clear_i = 1'b0;
      for (int c = 0; c < 4; c++) begin
         int j0, j1;
         j0 = (c == 0) ? 0 : 2;
         j1 = (c < 2) ? 1 : 3;
         req_valid = {1'b1, (c < 3)};
         req_dir   = 2'b11;
         rsrc[0] = 32'h2000_0000 + j0 * 16; rdst[0] = 32'h2000 + j0; rlen[0] = 16 * (j0 + 1);
         rsrc[1] = 32'h2000_0000 + j1 * 16; rdst[1] = 32'h2000 + j1; rlen[1] = 16 * (j1 + 1);
         #1;
         chk("t2_grant", 64'(req_ready), (c % 2 == 0) ? 64'd1 : 64'd2);
         cyc();
      end
      req_valid = '0;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back({k[0], 1'b1, 1'b0});
         serve(1, 32'h2000_0000 + k * 16, 16 * (k + 1), 0);
      end
      cyc();
      cyc();
      chk("t2_pend_end", 64'(pend[1]), 64'd0);

      // Full a2o FIFO with the channel never ready.
      for (int k = 0; k < 5; k++) send(0, 1'b0, 32'h3000_0000 + k * 16, 32'h3000 + k, 32 + k);
      req_valid[0] = 1'b1; req_dir[0] = 1'b0; rsrc[0] = 32'h3000_0050; rlen[0] = 32'd37;
      #1;
      chk("t3_stall", 64'(req_ready[0]), 64'd0);
      chk("t3_pend_full", 64'(pend[0]), 64'd5);
      done[0] = 1'b1; err[0] = 1'b1;
      cyc();
      done[0] = 1'b0; err[0] = 1'b0;
      chk("t3_issue_ignores_events", 64'(cfg_vld[0]), 64'd1);
      chk("t3_stall2", 64'(req_ready[0]), 64'd0);
      req_valid[1] = 1'b1; req_dir[1] = 1'b1; rsrc[1] = 32'h4000_0000; rdst[1] = 32'h4000; rlen[1] = 32'd8;
      #1;
      chk("t3_other_dir", 64'(req_ready), 64'd2);
      cyc();
      req_valid = '0;

      // Error paths drain the a2o queue; the next job issues right after each completion.
      exp_q.push_back(3'b001);
      serve(0, 32'h3000_0000, 32'd32, 1);
      cyc();
      chk("t4_next_after_err", 64'(cfg_vld[0]), 64'd1);
      exp_q.push_back(3'b001);
      serve(0, 32'h3000_0010, 32'd33, 2);
      cyc();
      chk("t4_next_after_errdone", 64'(cfg_vld[0]), 64'd1);
      exp_q.push_back(3'b000);
      serve(0, 32'h3000_0020, 32'd34, 3);
      cyc();

      // Simultaneous completion on both channels.
      chk("t5_both_issue", 64'(cfg_vld), 64'd3);
      chk("t5_a2o_src", 64'(cfg_src[0]), 64'h3000_0030);
      chk("t5_o2a_src", 64'(cfg_src[1]), 64'h4000_0000);
      cfg_rdy = 2'b11;
      cyc();
      cfg_rdy = 2'b00; start = 2'b11;
      cyc();
      start = 2'b00;
      cyc();
      exp_q.push_back(3'b000);
      exp_q.push_back(3'b110);
      done = 2'b11;
      cyc();
      done = 2'b00;
      chk("t5_cpl_c0", 64'(cpl_valid), 64'd0);
      cyc();
      chk("t5_cpl_a2o", 64'({cpl_valid, cpl_dir}), 64'b10);
      cyc();
      chk("t5_cpl_o2a", 64'({cpl_valid, cpl_dir}), 64'b11);
      cyc();
      chk("t5_cpl_idle", 64'(cpl_valid), 64'd0);

      // Flush mid-WAIT_DONE with two jobs queued behind the active one.
      send(0, 1'b0, 32'h5000_0000, 32'h5000, 32'd4);
      send(0, 1'b0, 32'h5000_0010, 32'h5001, 32'd5);
      cfg_rdy[0] = 1'b1;
      cyc();
      cfg_rdy[0] = 1'b0; start[0] = 1'b1;
      cyc();
      start[0] = 1'b0;
      cyc();
      chk("t6_pend_before", 64'(pend[0]), 64'd3);
      snap = cpl_cnt;
      clear_i = 1'b1; done[0] = 1'b1;
      cyc();
      clear_i = 1'b0; done[0] = 1'b0;
      chk("t6_pend_a2o", 64'(pend[0]), 64'd0);
      chk("t6_pend_o2a", 64'(pend[1]), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      repeat (4) cyc();
      chk("t6_no_cpl", 64'(cpl_cnt), 64'(snap));
      chk("t6_no_cfg", 64'(cfg_vld), 64'd0);

      // Zero-length job bypasses the channel.
      exp_q.push_back(3'b100);
      send(1, 1'b0, 32'h6000_0000, 32'h6000, 32'd0);
      chk("t7_cfg_c1", 64'(cfg_vld[0]), 64'd0);
      cyc();
      chk("t7_cfg_c2", 64'({cfg_vld[0], cpl_valid}), 64'd0);
      cyc();
      chk("t7_cpl_c3", 64'({cfg_vld[0], cpl_valid}), 64'b01);
      cyc();
      chk("t7_cpl_end", 64'(cpl_valid), 64'd0);
      chk("t7_pend_end", 64'(pend[0]), 64'd0);

      repeat (3) cyc();
      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
